// File: rtl/sfm_step_scheduler_if.sv
// sfm_step_scheduler_if
//  Groups the step-scheduler request inputs (step_tick, g_done) and all of its
//  strobe/status outputs. The slave modport is used by the scheduler itself and
//  the master modport by whatever issues ticks and consumes the strobes.
//  With SFM_SCHED_STATS_EN defined, step_lat/max_lat are added.
interface sfm_step_scheduler_if;
  logic        step_tick;
  logic        g_done;
  logic        sta;
  logic        sta_m;
  logic        sta_read_vdc;
  logic        sta_read_ia;
  logic        uab_valid;
  logic        sta_read_fifo;
  logic        done_sig;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
  logic [15:0] step_cnt;
`ifdef SFM_SCHED_STATS_EN
  logic [15:0] step_lat;
  logic [15:0] max_lat;

  modport slave (
    input  step_tick, g_done,
    output sta, sta_m, sta_read_vdc, sta_read_ia, uab_valid, sta_read_fifo,
           done_sig, busy, overrun, timeout_err, step_cnt, step_lat, max_lat
  );
  modport master (
    output step_tick, g_done,
    input  sta, sta_m, sta_read_vdc, sta_read_ia, uab_valid, sta_read_fifo,
           done_sig, busy, overrun, timeout_err, step_cnt, step_lat, max_lat
  );
`else
  modport slave (
    input  step_tick, g_done,
    output sta, sta_m, sta_read_vdc, sta_read_ia, uab_valid, sta_read_fifo,
           done_sig, busy, overrun, timeout_err, step_cnt
  );
  modport master (
    output step_tick, g_done,
    input  sta, sta_m, sta_read_vdc, sta_read_ia, uab_valid, sta_read_fifo,
           done_sig, busy, overrun, timeout_err, step_cnt
  );
`endif
endinterface

// File: rtl/sfm_step_scheduler.sv
// sfm_step_scheduler
//  Sequences one simulation step of the SFM source datapath: on step_tick it
//  issues sta, waits for the INV g-function done, then after M_LEAD cycles
//  issues sta_m and replays all fixed-latency strobes from one run counter.
//  Ports: clk, rst (sync, active high), bus (sfm_step_scheduler_if.slave):
//   in  step_tick, g_done
//   out sta, sta_m, sta_read_vdc, sta_read_ia, uab_valid, sta_read_fifo,
//       done_sig, busy, overrun (sticky), timeout_err (sticky), step_cnt[15:0]
//  Optional macro SFM_SCHED_STATS_EN adds step_lat/max_lat (sta->done latency).
//  All outputs are registered.
module sfm_step_scheduler #(
  parameter int LAT_RD_VDC  = 7,
  parameter int LAT_RD_IA   = 12,
  parameter int LAT_UAB     = 14,
  parameter int LAT_RD_FIFO = 37,
  parameter int LAT_DONE    = 39,
  parameter int M_LEAD      = 2,
  parameter int G_TIMEOUT   = 255
) (
  input logic                 clk,
  input logic                 rst,
  sfm_step_scheduler_if.slave bus
);
  localparam int RW = $clog2(LAT_DONE + 1);
  // Compare points are LAT-1: the registered output lands LAT cycles after sta_m.
  localparam logic [RW-1:0] C_VDC  = RW'(LAT_RD_VDC - 1);
  localparam logic [RW-1:0] C_IA   = RW'(LAT_RD_IA - 1);
  localparam logic [RW-1:0] C_UAB  = RW'(LAT_UAB - 1);
  localparam logic [RW-1:0] C_FIFO = RW'(LAT_RD_FIFO - 1);
  localparam logic [RW-1:0] C_DONE = RW'(LAT_DONE - 1);
  localparam logic [7:0]    C_TMO  = 8'(G_TIMEOUT);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_G, LEAD, RUN} state_t;
  state_t state, state_nxt;

  logic [7:0]    tmo_cnt;
  logic [3:0]    lead_cnt;
  logic [RW-1:0] run_cnt;

  logic sta_q, sta_m_q, vdc_q, ia_q, uab_q, fifo_q, done_q, busy_q, ovr_q, tmo_q;
  logic [15:0] step_cnt_q;

  logic sta_n, sta_m_n, vdc_n, ia_n, uab_n, fifo_n, done_n, busy_n, ovr_n, tmo_n;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (bus.step_tick) state_nxt = LAUNCH;
      LAUNCH: state_nxt = WAIT_G;
      WAIT_G: begin
        // g_done wins over a coincident timeout
        if (bus.g_done)            state_nxt = (M_LEAD == 0) ? RUN : LEAD;
        else if (tmo_cnt == C_TMO) state_nxt = IDLE;
      end
      LEAD:   if (int'(lead_cnt) == M_LEAD - 1) state_nxt = RUN;
      RUN:    if (run_cnt == C_DONE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output next-values (registered below)
  always_comb begin
    sta_n   = (state == LAUNCH);
    sta_m_n = (state != RUN) && (state_nxt == RUN);
    vdc_n   = (state == RUN) && (run_cnt == C_VDC);
    ia_n    = (state == RUN) && (run_cnt == C_IA);
    uab_n   = (state == RUN) && (run_cnt == C_UAB);
    fifo_n  = (state == RUN) && (run_cnt == C_FIFO);
    done_n  = (state == RUN) && (run_cnt == C_DONE);
    busy_n  = (state_nxt != IDLE);
    ovr_n   = bus.step_tick && (state != IDLE);
    tmo_n   = (state == WAIT_G) && !bus.g_done && (tmo_cnt == C_TMO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt    <= '0;
      lead_cnt   <= '0;
      run_cnt    <= '0;
      sta_q      <= 1'b0;
      sta_m_q    <= 1'b0;
      vdc_q      <= 1'b0;
      ia_q       <= 1'b0;
      uab_q      <= 1'b0;
      fifo_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      tmo_cnt  <= (state == WAIT_G) ? tmo_cnt + 8'd1 : '0;
      lead_cnt <= (state == LEAD) ? lead_cnt + 4'd1 : '0;
      run_cnt  <= (state == RUN) ? run_cnt + 1'b1 : '0;
      sta_q    <= sta_n;
      sta_m_q  <= sta_m_n;
      vdc_q    <= vdc_n;
      ia_q     <= ia_n;
      uab_q    <= uab_n;
      fifo_q   <= fifo_n;
      done_q   <= done_n;
      busy_q   <= busy_n;
      ovr_q    <= ovr_q | ovr_n;
      tmo_q    <= tmo_q | tmo_n;
      if (done_n) step_cnt_q <= step_cnt_q + 16'd1;
    end
  end

  assign bus.sta           = sta_q;
  assign bus.sta_m         = sta_m_q;
  assign bus.sta_read_vdc  = vdc_q;
  assign bus.sta_read_ia   = ia_q;
  assign bus.uab_valid     = uab_q;
  assign bus.sta_read_fifo = fifo_q;
  assign bus.done_sig      = done_q;
  assign bus.busy          = busy_q;
  assign bus.overrun       = ovr_q;
  assign bus.timeout_err   = tmo_q;
  assign bus.step_cnt      = step_cnt_q;

`ifdef SFM_SCHED_STATS_EN
  // lat_cnt is 0 in the sta cycle, so lat_cnt+1 in the cycle before done is
  // the sta->done distance seen on the done cycle.
  logic [15:0] lat_cnt, step_lat_q, max_lat_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt    <= '0;
      step_lat_q <= '0;
      max_lat_q  <= '0;
    end else begin
      lat_cnt <= (state == LAUNCH) ? '0 : lat_cnt + 16'd1;
      if (done_n) begin
        step_lat_q <= lat_cnt + 16'd1;
        if (lat_cnt + 16'd1 > max_lat_q) max_lat_q <= lat_cnt + 16'd1;
      end
    end
  end
  assign bus.step_lat = step_lat_q;
  assign bus.max_lat  = max_lat_q;
`endif
endmodule

// File: tb/tb_sfm_step_scheduler.sv
module tb_sfm_step_scheduler;
  logic clk;
  logic rst;
  sfm_step_scheduler_if bif();

  sfm_step_scheduler dut (.clk(clk), .rst(rst), .bus(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int id; int cyc;} ev_t;
  ev_t   exp_q[$];
  string nm[7] = '{"sta", "sta_m", "rd_vdc", "rd_ia", "uab", "rd_fifo", "done"};
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  logic [15:0] exp_steps = '0;

  task automatic push(input int id, input int c);
    ev_t e;
    e.id = id; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // advance one clock, then score all strobes at the falling edge
  task automatic cycle();
    logic [6:0] s;
    ev_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    s = {bif.done_sig, bif.sta_read_fifo, bif.uab_valid, bif.sta_read_ia,
         bif.sta_read_vdc, bif.sta_m, bif.sta};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_%s: got none, required pulse at cycle %0d", nm[e.id], e.cyc);
    end
    for (int i = 0; i < 7; i++) begin
      if (s[i] === 1'b1) begin
        checks++;
        if (exp_q.size() > 0 && exp_q[0].id == i && exp_q[0].cyc == cyc) e = exp_q.pop_front();
        else begin
          errors++;
          $display("FAIL strobe_%s: got pulse at cycle %0d, required none", nm[i], cyc);
        end
      end
    end
  endtask

  // full step with g_done at t0+gd; optional extra ticks at t0+x1/t0+x2; returns on done cycle
  task automatic step_seq(input int gd, input int x1, input int x2);
    int t0;
    t0 = cyc;
    push(0, t0 + 2);       push(1, t0 + gd + 3);  push(2, t0 + gd + 10);
    push(3, t0 + gd + 15); push(4, t0 + gd + 17); push(5, t0 + gd + 40);
    push(6, t0 + gd + 42);
    exp_steps = exp_steps + 16'd1;
    bif.step_tick = 1'b1;
    cycle();
    bif.step_tick = 1'b0;
    while (cyc < t0 + gd + 42) begin
      bif.g_done    = (cyc == t0 + gd);
      bif.step_tick = (x1 != 0 && cyc == t0 + x1) || (x2 != 0 && cyc == t0 + x2);
      if (cyc == t0 + gd + 20) begin
        checks++;
        if (bif.busy !== 1'b1) begin
          errors++; $display("FAIL busy_mid: got %b, required 1", bif.busy);
        end
      end
      cycle();
    end
    bif.g_done = 1'b0; bif.step_tick = 1'b0;
    checks++;
    if (bif.step_cnt !== exp_steps) begin
      errors++; $display("FAIL step_cnt: got %h, required %h", bif.step_cnt, exp_steps);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bif.step_tick = 1'b0; bif.g_done = 1'b0;
    cycle(); cycle();
    checks++;
    if ({bif.busy, bif.overrun, bif.timeout_err, bif.step_cnt} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b ovr=%b tmo=%b cnt=%h, required all 0",
               bif.busy, bif.overrun, bif.timeout_err, bif.step_cnt);
    end
`ifdef SFM_SCHED_STATS_EN
    checks++;
    if ({bif.step_lat, bif.max_lat} !== 32'd0) begin
      errors++; $display("FAIL reset_stats: got %h/%h, required 0", bif.step_lat, bif.max_lat);
    end
`endif
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    step_seq(10, 0, 0);
    cycle();
    checks++;
    if (bif.busy !== 1'b0 || bif.overrun !== 1'b0) begin
      errors++; $display("FAIL basic_end: got busy=%b ovr=%b, required 0/0", bif.busy, bif.overrun);
    end
  endtask

  task automatic test_overrun();
    // ticks mid-step and on the cycle the FSM heads back to IDLE
    step_seq(10, 30, 51);
    cycle();
    checks++;
    if (bif.overrun !== 1'b1) begin
      errors++; $display("FAIL overrun: got %b, required 1", bif.overrun);
    end
    repeat (3) cycle();
  endtask

  task automatic test_back_to_back();
    step_seq(10, 0, 0);
    step_seq(6, 0, 0);   // tick on the done cycle, FSM already IDLE
    step_seq(2, 0, 0);
    cycle();
    checks++;
    if (bif.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy=%b, required 0", bif.busy);
    end
  endtask

  task automatic test_timeout();
    int t0;
    t0 = cyc;
    push(0, t0 + 2);
    bif.step_tick = 1'b1;
    cycle();
    bif.step_tick = 1'b0;
    while (cyc < t0 + 200) cycle();
    checks++;
    if (bif.timeout_err !== 1'b0 || bif.busy !== 1'b1) begin
      errors++; $display("FAIL tmo_early: got tmo=%b busy=%b, required 0/1", bif.timeout_err, bif.busy);
    end
    while (cyc < t0 + 270) cycle();
    checks++;
    if (bif.timeout_err !== 1'b1 || bif.busy !== 1'b0) begin
      errors++; $display("FAIL tmo_set: got tmo=%b busy=%b, required 1/0", bif.timeout_err, bif.busy);
    end
    checks++;
    if (bif.step_cnt !== exp_steps) begin
      errors++; $display("FAIL tmo_cnt: got %h, required %h", bif.step_cnt, exp_steps);
    end
    // stray g_done while idle must not start anything
    bif.g_done = 1'b1;
    cycle();
    bif.g_done = 1'b0;
    repeat (4) cycle();
    checks++;
    if (bif.busy !== 1'b0) begin
      errors++; $display("FAIL gdone_idle: got busy=%b, required 0", bif.busy);
    end
    step_seq(8, 0, 0);
    cycle();
  endtask

  task automatic test_mid_reset();
    int t0;
    t0 = cyc;
    push(0, t0 + 2);  push(1, t0 + 13); push(2, t0 + 20);
    push(3, t0 + 25); push(4, t0 + 27);
    bif.step_tick = 1'b1;
    cycle();
    bif.step_tick = 1'b0;
    while (cyc < t0 + 33) begin   // cycle t0+33 has run_cnt == 20
      bif.g_done = (cyc == t0 + 10);
      cycle();
    end
    bif.g_done = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_steps = '0;
    checks++;
    if ({bif.sta, bif.sta_m, bif.sta_read_vdc, bif.sta_read_ia, bif.uab_valid,
         bif.sta_read_fifo, bif.done_sig, bif.busy, bif.overrun, bif.timeout_err} !== 10'd0
        || bif.step_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b ovr=%b tmo=%b cnt=%h, required all 0",
               bif.busy, bif.overrun, bif.timeout_err, bif.step_cnt);
    end
    while (cyc < t0 + 60) cycle();
    checks++;
    if (bif.busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle: got busy=%b, required 0", bif.busy);
    end
  endtask

  task automatic test_stats();
    step_seq(10, 0, 0);
`ifdef SFM_SCHED_STATS_EN
    checks++;
    if (bif.step_lat !== 16'd50 || bif.max_lat !== 16'd50) begin
      errors++; $display("FAIL stats_1: got lat=%0d max=%0d, required 50/50", bif.step_lat, bif.max_lat);
    end
`endif
    step_seq(4, 0, 0);
`ifdef SFM_SCHED_STATS_EN
    checks++;
    if (bif.step_lat !== 16'd44 || bif.max_lat !== 16'd50) begin
      errors++; $display("FAIL stats_2: got lat=%0d max=%0d, required 44/50", bif.step_lat, bif.max_lat);
    end
`endif
    cycle();
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.step_cnt_q = 16'hFFFE;
    cycle();
    release dut.step_cnt_q;
    cycle();
    exp_steps = 16'hFFFE;
    checks++;
    if (bif.step_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL wrap_preload: got %h, required fffe", bif.step_cnt);
    end
    step_seq(5, 0, 0);   // -> FFFF
    step_seq(5, 0, 0);   // -> 0000 on the done cycle
    cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    test_stats();
    test_wrap();
    repeat (5) cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover: got %0d pending strobes, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end
endmodule
